stack_based_alu: RTL and testbench
==================================

# stack_based_alu

Signed n-bit stack machine: push and pop operands on an internal LIFO and compute the sum or product of the top two entries. It is the arithmetic back-end of the expression solver. The infix-to-postfix converter's output is evaluated by driving one opcode per clock cycle.

## Interface
Parameters:
- n, 8, data width in bits (two's-complement signed)
- DEPTH, 32, stack capacity in entries (power of two, ≥ 2)

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RST_N  input  1  asynchronous active-low reset
- input_data  input  n  operand for push
- opcode  input  3  operation select, sampled every rising edge
- output_data  output  n  registered result / popped value
- overflow  output  1  registered signed-overflow flag of the last add/mul

One clock domain. Reset is asynchronous and active-low.

## Operation
Internal state:
- stack array of DEPTH × n bits
- count in 0..DEPTH
- top = entry at count-1; second = entry at count-2

Opcodes, executed at each rising edge:
- 000 NOP: nothing changes; output_data and overflow hold.
- 110 PUSH:
  - if count < DEPTH: store input_data at index count, count += 1.
  - if full: ignored, stack unchanged.
  - output_data holds; overflow ← 0.
- 111 POP:
  - if count > 0: output_data ← top, count −= 1.
  - if empty: output_data ← 0, stack unchanged.
  - overflow ← 0.
- 100 ADD, non-destructive (stack unchanged):
  - if count ≥ 2: output_data ← (second + top) mod 2^n.
  - overflow ← 1 iff both operands have the same sign and the sum's sign differs.
- 101 MUL, non-destructive (stack unchanged):
  - if count ≥ 2: output_data ← low n bits of the signed 2n-bit product second × top.
  - overflow ← 1 iff the full product is outside [−2^(n−1), 2^(n−1)−1].
- ADD/MUL with count < 2: output_data ← 0, overflow ← 0, stack unchanged.
- 001, 010, 011: treated as NOP.

Usage contract: a binary operator is evaluated as
1. ADD/MUL
2. capture output_data as input_data
3. POP, POP
4. PUSH

Subtraction is done by popping the right operand, pushing its negation, then ADD. The block contains no subtraction opcode.

## Timing
- Reset (RST_N low, asynchronous): count = 0, output_data = 0, overflow = 0. Stack contents are don't-care.
- Reset mid-operation: discards the in-flight op. The first rising edge after RST_N deasserts executes normally.
- Latency:
  - Each opcode takes effect on the rising edge where it is sampled.
  - output_data and overflow are valid immediately after that edge and hold until the next non-NOP edge.
- Throughput: one operation per cycle, no handshake. Holding an opcode for k edges executes it k times (e.g. POP held 2 cycles pops twice).
- A PUSH in the cycle after a POP writes to the slot just freed; no bypass hazards.
- Boundaries:
  - push when full is ignored, count stays DEPTH.
  - pop when empty returns 0.
  - count never wraps.

## Test plan
- Reset then POP → output_data=0, overflow=0; PUSH 5, PUSH 3, POP → output_data=3; POP → 5; POP → 0 (empty).
- PUSH 7, PUSH 6, ADD → output_data=13, overflow=0; POP → 6, confirming ADD left the stack intact; MUL with one entry → 0.
- n=8: PUSH 100, PUSH 50, ADD → output_data=−106 (0x96), overflow=1; MUL → 0x88, overflow=1; PUSH −4, PUSH 3, MUL (top two −4,3) → −12, overflow=0.
- Expression 2+3*4 via usage contract:
  - PUSH 3, PUSH 4, MUL → 12; POP, POP, PUSH 12.
  - PUSH 2, ADD → 14; POP, POP, PUSH 14; POP → 14.
- Subtraction 9−4:
  - PUSH 9, PUSH 4, POP → 4; PUSH −4, ADD → 5.
- Fill DEPTH entries then PUSH 99 → ignored; DEPTH POPs return entries in reverse order, next POP → 0.
- Assert RST_N low between PUSH and ADD → outputs 0 immediately without a clock edge; ADD after release → 0 (stack empty).

Source files
------------

// File: rtl/stack_based_alu.sv
// stack_based_alu
// Signed n-bit stack machine. Operands are pushed onto and popped off an internal
// LIFO. ADD and MUL combine the top two entries without changing the stack.
// Every operation executes on the rising edge where its opcode is sampled.
//
// Ports:
//   CLK          clock; all state changes on the rising edge
//   RST_N        asynchronous active-low reset
//   input_data   operand for PUSH
//   opcode       000 NOP, 110 PUSH, 111 POP, 100 ADD, 101 MUL, others NOP
//   output_data  registered result of the last POP/ADD/MUL
//   overflow     registered signed-overflow flag of the last ADD/MUL
module stack_based_alu #(
    parameter int unsigned n     = 8,
    parameter int unsigned DEPTH = 32
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [n-1:0] input_data,
    input  logic [2:0]   opcode,
    output logic [n-1:0] output_data,
    output logic         overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that count can hold DEPTH itself.
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b100;
    localparam logic [2:0] OpMul  = 3'b101;
    localparam logic [2:0] OpPush = 3'b110;
    localparam logic [2:0] OpPop  = 3'b111;

    logic [n-1:0]  stack_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [n-1:0]  out_q, out_d;
    logic          ovf_q, ovf_d;

    logic          push_en;
    logic [AW-1:0] wr_idx, top_idx, sec_idx;
    logic [n-1:0]  top, second;
    logic          is_full, is_empty, has_two;

    logic [n-1:0]    sum;
    logic            add_ovf;
    logic [2*n-1:0]  a_ext, b_ext, prod;
    logic            mul_ovf;

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign has_two  = (count_q >= CW'(2));

    // Indices are only used when the corresponding entry exists.
    assign wr_idx  = AW'(count_q);
    assign top_idx = AW'(count_q - CW'(1));
    assign sec_idx = AW'(count_q - CW'(2));
    assign top     = stack_q[top_idx];
    assign second  = stack_q[sec_idx];

    assign sum     = second + top;
    // Same-sign operands whose sum flips sign have overflowed.
    assign add_ovf = (second[n-1] == top[n-1]) && (sum[n-1] != top[n-1]);

    assign a_ext   = {{n{second[n-1]}}, second};
    assign b_ext   = {{n{top[n-1]}}, top};
    assign prod    = a_ext * b_ext;
    // Product fits in n bits only if bits [2n-1:n-1] are all copies of the sign.
    assign mul_ovf = !((&prod[2*n-1:n-1]) || !(|prod[2*n-1:n-1]));

    always_comb begin
        count_d = count_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        push_en = 1'b0;
        case (opcode)
            OpPush: begin
                ovf_d = 1'b0;
                if (!is_full) begin
                    push_en = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            OpPop: begin
                ovf_d = 1'b0;
                if (!is_empty) begin
                    out_d   = top;
                    count_d = count_q - CW'(1);
                end else begin
                    out_d = '0;
                end
            end
            OpAdd: begin
                out_d = has_two ? sum : '0;
                ovf_d = has_two && add_ovf;
            end
            OpMul: begin
                out_d = has_two ? prod[n-1:0] : '0;
                ovf_d = has_two && mul_ovf;
            end
            OpNop:   ;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    // Stack storage needs no reset: entries above count are never read.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            stack_q[wr_idx] <= input_data;
        end
    end

    assign output_data = out_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_stack_based_alu.sv
module tb_stack_based_alu;

    localparam int N     = 8;
    localparam int DEPTH = 32;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    logic         CLK;
    logic         RST_N;
    logic [N-1:0] input_data;
    logic [2:0]   opcode;
    logic [N-1:0] output_data;
    logic         overflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int           ms[$];
    logic [N-1:0] m_out;
    logic         m_ovf;

    // Scoreboard entries: {expected overflow, expected output_data}.
    logic [N:0] sb[$];

    stack_based_alu #(
        .n     (N),
        .DEPTH (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .input_data  (input_data),
        .opcode      (opcode),
        .output_data (output_data),
        .overflow    (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int sx(input logic [N-1:0] v);
        return int'($signed(v));
    endfunction

    // Integer-range model of the arithmetic, independent of bit tricks.
    task automatic model_step(input logic [2:0] op, input logic [N-1:0] d);
        int a, b, r;
        case (op)
            OP_PUSH: begin
                if (ms.size() < DEPTH) ms.push_back(sx(d));
                m_ovf = 1'b0;
            end
            OP_POP: begin
                if (ms.size() > 0) m_out = N'(ms.pop_back());
                else m_out = '0;
                m_ovf = 1'b0;
            end
            OP_ADD, OP_MUL: begin
                if (ms.size() >= 2) begin
                    a = ms[ms.size()-2];
                    b = ms[ms.size()-1];
                    r = (op == OP_ADD) ? a + b : a * b;
                    m_out = N'(r);
                    m_ovf = (r > 127) || (r < -128);
                end else begin
                    m_out = '0;
                    m_ovf = 1'b0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [2:0] op, input logic [N-1:0] d, input string name);
        logic [N:0] exp;
        @(negedge CLK);
        opcode     = op;
        input_data = d;
        model_step(op, d);
        sb.push_back({m_ovf, m_out});
        @(posedge CLK);
        #1;
        exp = sb.pop_front();
        n_checks++;
        if ({overflow, output_data} !== exp) begin
            $display("FAIL %s op=%b: got data=%h ovf=%b, expected data=%h ovf=%b",
                     name, op, output_data, overflow, exp[N-1:0], exp[N]);
        end else begin
            n_pass++;
        end
        @(negedge CLK);
        opcode = OP_NOP;
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if (output_data !== 8'h00 || overflow !== 1'b0) begin
            $display("FAIL %s: got data=%h ovf=%b, expected data=00 ovf=0",
                     name, output_data, overflow);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        RST_N      = 1'b0;
        opcode     = OP_NOP;
        input_data = '0;
        ms.delete();
        m_out = '0;
        m_ovf = 1'b0;
        #12;
        check_idle("reset_state");
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_push_pop();
        do_op(OP_POP, 8'd0, "pop_empty_first");
        do_op(OP_PUSH, 8'd5, "push5");
        do_op(OP_PUSH, 8'd3, "push3");
        do_op(OP_POP, 8'd0, "pop3");
        do_op(OP_POP, 8'd0, "pop5");
        do_op(OP_POP, 8'd0, "pop_empty");
    endtask

    task automatic test_add_nondestructive();
        do_op(OP_PUSH, 8'd7, "push7");
        do_op(OP_PUSH, 8'd6, "push6");
        do_op(OP_ADD, 8'd0, "add13");
        do_op(OP_POP, 8'd0, "pop6_after_add");
        do_op(OP_MUL, 8'd0, "mul_one_entry");
        do_op(OP_POP, 8'd0, "pop7");
    endtask

    task automatic test_overflow();
        do_op(OP_PUSH, 8'd100, "push100");
        do_op(OP_PUSH, 8'd50, "push50");
        do_op(OP_ADD, 8'd0, "add_ovf");
        do_op(OP_MUL, 8'd0, "mul_ovf");
        do_op(OP_PUSH, 8'hFC, "push_m4");
        do_op(OP_PUSH, 8'd3, "push3b");
        do_op(OP_MUL, 8'd0, "mul_m12");
        do_op(OP_PUSH, 8'h80, "push_m128");
        do_op(OP_PUSH, 8'hFF, "push_m1");
        do_op(OP_MUL, 8'd0, "mul_m128_m1");
        do_op(OP_ADD, 8'd0, "add_m129");
        for (int i = 0; i < 6; i++) do_op(OP_POP, 8'd0, "drain_ovf");
    endtask

    task automatic test_nop();
        do_op(OP_PUSH, 8'd20, "push20");
        do_op(OP_PUSH, 8'd30, "push30");
        do_op(OP_ADD, 8'd0, "add50");
        for (int k = 0; k < 4; k++) do_op(3'(k), 8'hAA, "nop_hold");
        do_op(OP_POP, 8'd0, "pop30_after_nop");
        do_op(OP_POP, 8'd0, "pop20_after_nop");
    endtask

    task automatic test_expression();
        logic [N-1:0] cap;
        do_op(OP_PUSH, 8'd3, "expr_push3");
        do_op(OP_PUSH, 8'd4, "expr_push4");
        do_op(OP_MUL, 8'd0, "expr_mul12");
        cap = m_out;
        do_op(OP_POP, 8'd0, "expr_pop_a");
        do_op(OP_POP, 8'd0, "expr_pop_b");
        do_op(OP_PUSH, cap, "expr_push12");
        do_op(OP_PUSH, 8'd2, "expr_push2");
        do_op(OP_ADD, 8'd0, "expr_add14");
        cap = m_out;
        do_op(OP_POP, 8'd0, "expr_pop_c");
        do_op(OP_POP, 8'd0, "expr_pop_d");
        do_op(OP_PUSH, cap, "expr_push14");
        do_op(OP_POP, 8'd0, "expr_pop14");
    endtask

    task automatic test_subtract();
        logic [N-1:0] r;
        do_op(OP_PUSH, 8'd9, "sub_push9");
        do_op(OP_PUSH, 8'd4, "sub_push4");
        do_op(OP_POP, 8'd0, "sub_pop4");
        r = m_out;
        do_op(OP_PUSH, -r, "sub_push_m4");
        do_op(OP_ADD, 8'd0, "sub_add5");
        do_op(OP_POP, 8'd0, "sub_drain_a");
        do_op(OP_POP, 8'd0, "sub_drain_b");
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) do_op(OP_PUSH, 8'(i * 7 + 1), "fill_push");
        do_op(OP_PUSH, 8'd99, "push_full_ignored");
        for (int i = 0; i < DEPTH; i++) do_op(OP_POP, 8'd0, "fill_pop");
        do_op(OP_POP, 8'd0, "pop_after_fill");
    endtask

    task automatic test_back_to_back();
        // POP immediately followed by PUSH reuses the freed slot.
        do_op(OP_PUSH, 8'd11, "b2b_push11");
        do_op(OP_PUSH, 8'd22, "b2b_push22");
        do_op(OP_POP, 8'd0, "b2b_pop22");
        do_op(OP_PUSH, 8'd33, "b2b_push33");
        do_op(OP_ADD, 8'd0, "b2b_add44");
        do_op(OP_POP, 8'd0, "b2b_pop33");
        do_op(OP_POP, 8'd0, "b2b_pop11");
    endtask

    task automatic test_async_reset();
        do_op(OP_PUSH, 8'd5, "ar_push5");
        do_op(OP_PUSH, 8'd6, "ar_push6");
        do_op(OP_ADD, 8'd0, "ar_add11");
        do_op(OP_PUSH, 8'd2, "ar_push2");
        #2;
        RST_N = 1'b0;
        ms.delete();
        m_out = '0;
        m_ovf = 1'b0;
        #1;
        check_idle("async_reset_no_edge");
        @(negedge CLK);
        RST_N = 1'b1;
        do_op(OP_ADD, 8'd0, "add_after_reset");
        do_op(OP_POP, 8'd0, "pop_after_reset");
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_add_nondestructive();
        test_overflow();
        test_nop();
        test_expression();
        test_subtract();
        test_fill();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
